// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the minisoc GPIO controller.
//   - Register offsets (word index taken from addr[4:2]).
//   - gpio_reg_e: enum used to decode the register select field.
package gpio_pkg;

    localparam logic [2:0] GPIO_IN     = 3'd0;
    localparam logic [2:0] GPIO_OUT    = 3'd1;
    localparam logic [2:0] GPIO_DIR    = 3'd2;
    localparam logic [2:0] GPIO_IE     = 3'd3;
    localparam logic [2:0] GPIO_EDGE   = 3'd4;
    localparam logic [2:0] GPIO_STATUS = 3'd5;
    localparam logic [2:0] GPIO_SET    = 3'd6;
    localparam logic [2:0] GPIO_CLR    = 3'd7;

    typedef enum logic [2:0] {
        REG_IN     = GPIO_IN,
        REG_OUT    = GPIO_OUT,
        REG_DIR    = GPIO_DIR,
        REG_IE     = GPIO_IE,
        REG_EDGE   = GPIO_EDGE,
        REG_STATUS = GPIO_STATUS,
        REG_SET    = GPIO_SET,
        REG_CLR    = GPIO_CLR
    } gpio_reg_e;

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: single-pin input filter, instantiated per pin by gpio_ctrl
// only when GPIO_DEBOUNCE_EN is defined.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   sync_i    - synchronised pin input
//   filt_o    - filtered level; follows sync_i only after it has differed
//               from the current filtered level for DEBOUNCE_CYCLES cycles
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_i,
    output logic filt_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
            // Input has disagreed long enough: accept it.
            filt_q <= ~filt_q;
            cnt_q  <= '0;
        end else if (sync_i == filt_q) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO controller on the minisoc peripheral bus.
// Optional feature macro: GPIO_DEBOUNCE_EN (per-pin debounce filter).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   gpio_req/write      - bus request, 1 = write
//   gpio_wstrb/addr     - byte enables, byte address (only [4:2] decoded)
//   gpio_wdata          - write data
//   gpio_ready          - always 1
//   gpio_rvalid/rdata   - read response, one cycle after the read request
//   gpio_irq            - registered |(STATUS & IE)
//   GPIO                - pads, driven from OUT where DIR=1, else high-Z
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int AW              = 12,
    parameter int DW              = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gpio_req,
    input  logic              gpio_write,
    input  logic [DW/8-1:0]   gpio_wstrb,
    input  logic [AW-1:0]     gpio_addr,
    input  logic [DW-1:0]     gpio_wdata,
    output logic              gpio_ready,
    output logic              gpio_rvalid,
    output logic [DW-1:0]     gpio_rdata,
    output logic              gpio_irq,
    inout  wire  [WIDTH-1:0]  GPIO
);

    if (WIDTH < 1 || WIDTH > DW || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("gpio_ctrl: WIDTH must be 1..DW and DEBOUNCE_CYCLES >= 1");
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ie_q, ie_d;
    logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] filt, evt, wmask, wdata_w;
    logic             rvalid_q, irq_q;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             wr, rd;
    gpio_reg_e        reg_sel;
    logic             unused_bits;

    assign wr      = gpio_req & gpio_write;
    assign rd      = gpio_req & ~gpio_write;
    assign reg_sel = gpio_reg_e'(gpio_addr[4:2]);
    assign wdata_w = gpio_wdata[WIDTH-1:0];

    // Only addr[4:2], the low WIDTH data bits and their byte strobes matter.
    assign unused_bits = ^{gpio_addr, gpio_wdata, gpio_wstrb};

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign wmask[i] = gpio_wstrb[i/8];
        assign GPIO[i]  = dir_q[i] ? out_q[i] : 1'bz;
    end

`ifdef GPIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .sync_i(sync2_q[i]),
            .filt_o(filt[i])
        );
    end
`else
    logic [WIDTH-1:0] filt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) filt_q <= '0;
        else     filt_q <= sync2_q;
    end

    assign filt = filt_q;
`endif

    // Edge select per pin: 1 = rising, 0 = falling.
    assign evt = (edge_sel_q & filt & ~prev_q) | (~edge_sel_q & ~filt & prev_q);

    always_comb begin
        // NOTE: every output gets a default first, so no latches are inferred.
        out_d      = out_q;
        dir_d      = dir_q;
        ie_d       = ie_q;
        edge_sel_d = edge_sel_q;
        status_d   = status_q;
        if (wr) begin
            unique case (reg_sel)
                REG_OUT:    out_d      = (out_q & ~wmask) | (wdata_w & wmask);
                REG_DIR:    dir_d      = (dir_q & ~wmask) | (wdata_w & wmask);
                REG_IE:     ie_d       = (ie_q & ~wmask) | (wdata_w & wmask);
                REG_EDGE:   edge_sel_d = (edge_sel_q & ~wmask) | (wdata_w & wmask);
                REG_STATUS: status_d   = status_q & ~(wdata_w & wmask);
                REG_SET:    out_d      = out_q | (wdata_w & wmask);
                REG_CLR:    out_d      = out_q & ~(wdata_w & wmask);
                default:    ;
            endcase
        end
        // Events are ORed in after the clear so a same-cycle event wins.
        status_d = status_d | evt;
    end

    always_comb begin
        rdata_d = '0;
        unique case (reg_sel)
            REG_IN:     rdata_d[WIDTH-1:0] = filt;
            REG_OUT:    rdata_d[WIDTH-1:0] = out_q;
            REG_DIR:    rdata_d[WIDTH-1:0] = dir_q;
            REG_IE:     rdata_d[WIDTH-1:0] = ie_q;
            REG_EDGE:   rdata_d[WIDTH-1:0] = edge_sel_q;
            REG_STATUS: rdata_d[WIDTH-1:0] = status_q;
            default:    ;  // SET and CLR read as zero
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            dir_q      <= '0;
            ie_q       <= '0;
            edge_sel_q <= '0;
            status_q   <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            ie_q       <= ie_d;
            edge_sel_q <= edge_sel_d;
            status_q   <= status_d;
            sync1_q    <= GPIO;
            sync2_q    <= sync1_q;
            prev_q     <= filt;
            rvalid_q   <= rd;
            if (rd) rdata_q <= rdata_d;  // held until the next read
            irq_q      <= |(status_q & ie_q);
        end
    end

    assign gpio_ready  = 1'b1;
    assign gpio_rvalid = rvalid_q;
    assign gpio_rdata  = rdata_q;
    assign gpio_irq    = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed, table-driven bench for gpio_ctrl (WIDTH=16).
// Drive on the falling edge, sample on the falling edge.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    localparam int WIDTH = 16;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DB    = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT   = DB;
`else
    localparam int LAT   = 0;
`endif

    logic              clk, rst;
    logic              req, write;
    logic [DW/8-1:0]   wstrb;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic              ready, rvalid, irq;
    logic [DW-1:0]     rdata;
    logic [WIDTH-1:0]  tb_oe, tb_val;
    wire  [WIDTH-1:0]  gpio_pad;

    int checks   = 0;
    int failures = 0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_tb_pad
        assign gpio_pad[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    gpio_ctrl #(
        .WIDTH(WIDTH), .AW(AW), .DW(DW), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_req   (req),
        .gpio_write (write),
        .gpio_wstrb (wstrb),
        .gpio_addr  (addr),
        .gpio_wdata (wdata),
        .gpio_ready (ready),
        .gpio_rvalid(rvalid),
        .gpio_rdata (rdata),
        .gpio_irq   (irq),
        .GPIO       (gpio_pad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  wr_reg;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  rd_reg;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    // Garbage in the undecoded address bits must be ignored.
    function automatic logic [AW-1:0] a(input logic [2:0] r);
        return {7'h2B, r, 2'b01};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] r, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        req = 1'b1; write = 1'b1; addr = a(r); wdata = d; wstrb = s;
        @(negedge clk);
        req = 1'b0; write = 1'b0; wstrb = '0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] r, input logic [31:0] exp);
        @(negedge clk);
        check({name, "_rvalid_idle"}, {31'd0, rvalid}, 32'd0);
        req = 1'b1; write = 1'b0; addr = a(r);
        @(negedge clk);
        req = 1'b0;
        check({name, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        check(name, rdata, exp);
    endtask

`ifdef GPIO_DEBOUNCE_EN
    // Pulse pin1 high for len cycles while polling IN back-to-back.
    task automatic pulse_poll(input int len, output logic seen);
        seen = 1'b0;
        @(negedge clk);
        req = 1'b1; write = 1'b0; addr = a(GPIO_IN);
        for (int c = 0; c < len + 30; c++) begin
            if (c == 0)   tb_val[1] = 1'b1;
            if (c == len) tb_val[1] = 1'b0;
            @(negedge clk);
            if (rvalid) seen = seen | rdata[1];
        end
        req = 1'b0;
    endtask
`endif

    initial begin
        logic seen;
        vecs[0]  = '{GPIO_SET,    32'h0000_0002, 4'hF, GPIO_OUT,  32'h0000_00A7};
        vecs[1]  = '{GPIO_CLR,    32'h0000_0080, 4'hF, GPIO_OUT,  32'h0000_0027};
        vecs[2]  = '{GPIO_OUT,    32'h0000_0000, 4'hF, GPIO_OUT,  32'h0000_0000};
        vecs[3]  = '{GPIO_OUT,    32'h0000_BEEF, 4'h2, GPIO_OUT,  32'h0000_BE00};
        vecs[4]  = '{GPIO_OUT,    32'hFFFF_FFFF, 4'hF, GPIO_OUT,  32'h0000_FFFF};
        vecs[5]  = '{GPIO_CLR,    32'h0000_FFFF, 4'h1, GPIO_OUT,  32'h0000_FF00};
        vecs[6]  = '{GPIO_SET,    32'h0000_00FF, 4'h0, GPIO_OUT,  32'h0000_FF00};
        vecs[7]  = '{GPIO_SET,    32'h0000_0000, 4'hF, GPIO_SET,  32'h0000_0000};
        vecs[8]  = '{GPIO_CLR,    32'h0000_0000, 4'hF, GPIO_CLR,  32'h0000_0000};
        vecs[9]  = '{GPIO_IE,     32'h1234_5678, 4'hC, GPIO_IE,   32'h0000_0000};
        vecs[10] = '{GPIO_IE,     32'h1234_5678, 4'h3, GPIO_IE,   32'h0000_5678};
        vecs[11] = '{GPIO_EDGE,   32'h0000_ABCD, 4'h1, GPIO_EDGE, 32'h0000_00CD};
        vecs[12] = '{GPIO_DIR,    32'h0000_FFFF, 4'hF, GPIO_IN,   32'h0000_FF00};
        vecs[13] = '{GPIO_IE,     32'h0000_0000, 4'hF, GPIO_IE,   32'h0000_0000};
        vecs[14] = '{GPIO_EDGE,   32'h0000_0000, 4'hF, GPIO_EDGE, 32'h0000_0000};

        rst = 1'b1; req = 1'b0; write = 1'b0; wstrb = '0; addr = '0; wdata = '0;
        tb_oe = '1; tb_val = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rdata",  rdata, 32'd0);
        check("rst_irq",    {31'd0, irq}, 32'd0);
        check("rst_ready",  {31'd0, ready}, 32'd1);
        rst = 1'b0;
        rd_chk("rst_dir",    GPIO_DIR,    32'd0);
        rd_chk("rst_out",    GPIO_OUT,    32'd0);
        rd_chk("rst_ie",     GPIO_IE,     32'd0);
        rd_chk("rst_edge",   GPIO_EDGE,   32'd0);
        rd_chk("rst_status", GPIO_STATUS, 32'd0);

        // Input path with pins released by the DUT.
        tb_val = 16'h5A3C;
        repeat (4 + LAT) @(negedge clk);
        rd_chk("in_ext", GPIO_IN, 32'h0000_5A3C);

        // Output drive and loopback.
        tb_oe = '0;
        bus_write(GPIO_DIR, 32'h0000_FFFF, 4'hF);
        bus_write(GPIO_OUT, 32'h0000_00A5, 4'hF);
        check("pad_out", {16'd0, gpio_pad}, 32'h0000_00A5);
        rd_chk("out_a5", GPIO_OUT, 32'h0000_00A5);
        repeat (3 + LAT) @(negedge clk);
        rd_chk("in_loop", GPIO_IN, 32'h0000_00A5);

        for (int i = 0; i < 15; i++) begin
            bus_write(vecs[i].wr_reg, vecs[i].wdata, vecs[i].wstrb);
            rd_chk($sformatf("vec%0d", i), vecs[i].rd_reg, vecs[i].exp);
        end

        // Hand pads back to the bench and clear stale events.
        bus_write(GPIO_DIR, 32'd0, 4'hF);
        tb_oe = '1; tb_val = '0;
        repeat (4 + LAT) @(negedge clk);
        bus_write(GPIO_STATUS, 32'h0000_FFFF, 4'hF);
        rd_chk("status_clean", GPIO_STATUS, 32'd0);
        check("irq_clean", {31'd0, irq}, 32'd0);

        // Rising edge on pin0: STATUS at edge k+3, irq at edge k+4.
        bus_write(GPIO_IE,   32'h1, 4'hF);
        bus_write(GPIO_EDGE, 32'h1, 4'hF);
        @(negedge clk);
        tb_val[0] = 1'b1;
        repeat (3 + LAT) @(negedge clk);
        req = 1'b1; write = 1'b0; addr = a(GPIO_STATUS);
        check("irq_pre", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("status_pre_rvalid", {31'd0, rvalid}, 32'd1);
        check("status_pre", rdata, 32'd0);
        check("irq_k3", {31'd0, irq}, 32'd0);
        @(negedge clk);
        req = 1'b0;
        check("status_rise_rvalid", {31'd0, rvalid}, 32'd1);
        check("status_rise", rdata, 32'h1);
        check("irq_k4", {31'd0, irq}, 32'd1);

        // W1C drops the interrupt.
        bus_write(GPIO_STATUS, 32'h1, 4'hF);
        @(negedge clk);
        check("irq_w1c", {31'd0, irq}, 32'd0);
        rd_chk("status_w1c", GPIO_STATUS, 32'd0);

        // Falling edge on a rising-edge pin is ignored.
        tb_val[0] = 1'b0;
        repeat (5 + LAT) @(negedge clk);
        rd_chk("no_fall_evt", GPIO_STATUS, 32'd0);

        // Falling edge on pin3 colliding with a W1C of the same bit.
        tb_val[3] = 1'b1;
        repeat (5 + LAT) @(negedge clk);
        rd_chk("no_rise_evt", GPIO_STATUS, 32'd0);
        @(negedge clk);
        tb_val[3] = 1'b0;
        repeat (3 + LAT) @(negedge clk);
        req = 1'b1; write = 1'b1; addr = a(GPIO_STATUS); wdata = 32'h8; wstrb = 4'hF;
        @(negedge clk);
        req = 1'b0; write = 1'b0; wstrb = '0;
        rd_chk("collision", GPIO_STATUS, 32'h8);
        check("irq_masked", {31'd0, irq}, 32'd0);
        bus_write(GPIO_STATUS, 32'h8, 4'h2);
        rd_chk("w1c_strobe_off", GPIO_STATUS, 32'h8);
        bus_write(GPIO_STATUS, 32'h8, 4'h1);
        rd_chk("w1c_strobe_on", GPIO_STATUS, 32'd0);

        // Reset during a pending read response.
        tb_val[0] = 1'b1;
        repeat (5 + LAT) @(negedge clk);
        check("irq_before_rst", {31'd0, irq}, 32'd1);
        req = 1'b1; write = 1'b0; addr = a(GPIO_IE);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_mid_rdata",  rdata, 32'd0);
        check("rst_mid_irq",    {31'd0, irq}, 32'd0);
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
        rd_chk("rst_mid_ie",   GPIO_IE,   32'd0);
        rd_chk("rst_mid_edge", GPIO_EDGE, 32'd0);
        repeat (4 + LAT) @(negedge clk);
        check("rst_mid_irq_after", {31'd0, irq}, 32'd0);

`ifdef GPIO_DEBOUNCE_EN
        tb_val = '0;
        bus_write(GPIO_EDGE, 32'h2, 4'hF);
        repeat (10) @(negedge clk);
        bus_write(GPIO_STATUS, 32'h0000_FFFF, 4'hF);
        pulse_poll(3, seen);
        check("db_short_in", {31'd0, seen}, 32'd0);
        rd_chk("db_short_status", GPIO_STATUS, 32'd0);
        pulse_poll(6, seen);
        check("db_long_in", {31'd0, seen}, 32'd1);
        rd_chk("db_long_status", GPIO_STATUS, 32'h2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
